// File: rtl/data_memory.sv
// Byte-addressable 4 KiB little-endian data memory for the MEM stage.
// Synchronous byte/word stores, combinational sign-extended byte or word loads.
module data_memory #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    input  logic              word_or_byte
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_b0;
    logic [ADDR_W-1:0] addr_b1;
    logic [ADDR_W-1:0] addr_b2;
    logic [ADDR_W-1:0] addr_b3;

    // Word lanes are formed by replacing the low two bits, so a word never wraps or straddles.
    assign addr_b0 = {addr[ADDR_W-1:2], 2'b00};
    assign addr_b1 = {addr[ADDR_W-1:2], 2'b01};
    assign addr_b2 = {addr[ADDR_W-1:2], 2'b10};
    assign addr_b3 = {addr[ADDR_W-1:2], 2'b11};

    // Reset (active-high despite the _n name) clears every byte and wins over a same-edge store.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (mem_write) begin
            if (word_or_byte) begin
                mem_q[addr_b0] <= write_data[7:0];
                mem_q[addr_b1] <= write_data[15:8];
                mem_q[addr_b2] <= write_data[23:16];
                mem_q[addr_b3] <= write_data[31:24];
            end else begin
                mem_q[addr] <= write_data[7:0];
            end
        end
    end

    always_comb begin
        read_data = '0;
        if (!reset_n && mem_read) begin
            if (word_or_byte) begin
                read_data = {mem_q[addr_b3], mem_q[addr_b2], mem_q[addr_b1], mem_q[addr_b0]};
            end else begin
                read_data = {{(DATA_W-8){mem_q[addr][7]}}, mem_q[addr]};
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory: reset, byte/word access, enables,
// address boundary, read-during-write and reset arriving mid-store.
module tb_data_memory;

    logic        clk;
    logic        reset_n;
    logic [11:0] addr;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        word_or_byte;

    int errors;
    int checks;

    data_memory dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .addr        (addr),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .write_data  (write_data),
        .read_data   (read_data),
        .word_or_byte(word_or_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Store driven after a falling edge, committed on the next rising edge.
    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic wob);
        @(negedge clk);
        addr         = a;
        write_data   = d;
        word_or_byte = wob;
        mem_write    = 1'b1;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
    endtask

    task automatic set_read(input logic [11:0] a, input logic wob);
        addr         = a;
        word_or_byte = wob;
        mem_read     = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        set_read(12'h123, 1'b1);
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_word_read: got %h expected %h", read_data, 32'h0);
        end
        set_read(12'h0AA, 1'b0);
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_byte_read: got %h expected %h", read_data, 32'h0);
        end
        @(negedge clk);
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_read(12'(i * 12'h554), 1'b1);
            checks++;
            if (read_data !== 32'h0) begin
                errors++;
                $display("[TB] FAIL post_reset_word[%0d]: got %h expected %h", i, read_data, 32'h0);
            end
        end
    endtask

    task automatic test_byte;
        do_write(12'h0AA, 32'hFFFF_FF11, 1'b0);
        set_read(12'h0AA, 1'b0);
        checks++;
        if (read_data !== 32'h0000_0011) begin
            errors++;
            $display("[TB] FAIL byte_read_0AA: got %h expected %h", read_data, 32'h0000_0011);
        end
        set_read(12'h0A8, 1'b1);
        checks++;
        if (read_data !== 32'h0011_0000) begin
            errors++;
            $display("[TB] FAIL word_read_0A8: got %h expected %h", read_data, 32'h0011_0000);
        end
    endtask

    task automatic test_word;
        logic [11:0] addrs [4] = '{12'h100, 12'h103, 12'h100, 12'h101};
        logic        wobs  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] exps  [4] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hFFFF_FFEF, 32'hFFFF_FFBE};
        do_write(12'h100, 32'hDEAD_BEEF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            set_read(addrs[i], wobs[i]);
            checks++;
            if (read_data !== exps[i]) begin
                errors++;
                $display("[TB] FAIL word_vec[%0d] addr=%h: got %h expected %h", i, addrs[i], read_data, exps[i]);
            end
        end
        do_write(12'h106, 32'h0000_007F, 1'b0);
        set_read(12'h106, 1'b0);
        checks++;
        if (read_data !== 32'h0000_007F) begin
            errors++;
            $display("[TB] FAIL byte_positive_sign: got %h expected %h", read_data, 32'h0000_007F);
        end
        set_read(12'h104, 1'b1);
        checks++;
        if (read_data !== 32'h007F_0000) begin
            errors++;
            $display("[TB] FAIL neighbour_word_104: got %h expected %h", read_data, 32'h007F_0000);
        end
    endtask

    task automatic test_enables;
        addr         = 12'h100;
        word_or_byte = 1'b1;
        mem_read     = 1'b0;
        #1;
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL read_disabled: got %h expected %h", read_data, 32'h0);
        end
        @(negedge clk);
        addr         = 12'h0AA;
        write_data   = 32'h0000_0055;
        word_or_byte = 1'b0;
        mem_write    = 1'b0;
        @(posedge clk);
        #1;
        set_read(12'h0AA, 1'b0);
        checks++;
        if (read_data !== 32'h0000_0011) begin
            errors++;
            $display("[TB] FAIL write_disabled: got %h expected %h", read_data, 32'h0000_0011);
        end
    endtask

    task automatic test_boundary;
        do_write(12'hFFE, 32'h0102_0304, 1'b1);
        set_read(12'hFFF, 1'b0);
        checks++;
        if (read_data !== 32'h0000_0001) begin
            errors++;
            $display("[TB] FAIL byte_read_FFF: got %h expected %h", read_data, 32'h0000_0001);
        end
        set_read(12'hFFC, 1'b0);
        checks++;
        if (read_data !== 32'h0000_0004) begin
            errors++;
            $display("[TB] FAIL byte_read_FFC: got %h expected %h", read_data, 32'h0000_0004);
        end
        set_read(12'hFFD, 1'b1);
        checks++;
        if (read_data !== 32'h0102_0304) begin
            errors++;
            $display("[TB] FAIL word_read_FFD: got %h expected %h", read_data, 32'h0102_0304);
        end
        set_read(12'h000, 1'b1);
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL word_read_000: got %h expected %h", read_data, 32'h0);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        addr         = 12'h200;
        write_data   = 32'hCAFE_F00D;
        word_or_byte = 1'b1;
        mem_read     = 1'b1;
        mem_write    = 1'b1;
        #1;
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rdw_before_edge: got %h expected %h", read_data, 32'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (read_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("[TB] FAIL rdw_after_edge: got %h expected %h", read_data, 32'hCAFE_F00D);
        end
        write_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        checks++;
        if (read_data !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL back_to_back_word: got %h expected %h", read_data, 32'h1234_5678);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        addr         = 12'h100;
        write_data   = 32'hA5A5_A5A5;
        word_or_byte = 1'b1;
        mem_write    = 1'b1;
        mem_read     = 1'b1;
        #2;
        reset_n = 1'b1;
        #1;
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset_read: got %h expected %h", read_data, 32'h0);
        end
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        set_read(12'h100, 1'b1);
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL write_lost_100: got %h expected %h", read_data, 32'h0);
        end
        set_read(12'h0AA, 1'b0);
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL cleared_0AA: got %h expected %h", read_data, 32'h0);
        end
        set_read(12'hFFC, 1'b1);
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL cleared_FFC: got %h expected %h", read_data, 32'h0);
        end
        set_read(12'h200, 1'b1);
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL cleared_200: got %h expected %h", read_data, 32'h0);
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        reset_n      = 1'b1;
        addr         = 12'h0;
        mem_write    = 1'b0;
        mem_read     = 1'b0;
        write_data   = 32'h0;
        word_or_byte = 1'b0;
        #2;
        test_reset();
        test_byte();
        test_word();
        test_enables();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
